// File: rtl/alu_issue_stage.sv
// Issue/writeback wrapper around the combinational alu: operand fetch with
// forwarding from E, a single-entry E stage, a W output register and sticky flags.
module alu_issue_stage #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    localparam int RW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_opcode,
    input  logic [RW-1:0]    in_rd,
    input  logic [RW-1:0]    in_rs1,
    input  logic [RW-1:0]    in_rs2,
    input  logic             in_use_imm,
    input  logic [WIDTH-1:0] in_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RW-1:0]    out_rd,
    output logic [2:0]       out_flags,
    output logic [1:0]       sticky_flags,
    input  logic             sticky_clr
);

    logic [WIDTH-1:0] rf [NREG];

    logic             vld_p1;
    logic [4:0]       op_p1;
    logic [RW-1:0]    rd_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;

    logic             vld_p2;
    logic [WIDTH-1:0] res_p2;
    logic [RW-1:0]    rd_p2;
    logic [2:0]       flags_p2;
    logic [1:0]       sticky_q;

    logic             e_move;
    logic             accept;
    logic             fwd_a;
    logic             fwd_b;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [1:0]       sticky_ev;
    logic [1:0]       sticky_nxt;

    assign e_move   = vld_p1 & (~vld_p2 | out_ready);
    assign in_ready = ~vld_p1 | e_move;
    assign accept   = in_valid & in_ready;

    // The RF is written on the E->W edge, so only the instruction in E can be newer than the RF.
    assign fwd_a = e_move && (rd_p1 != '0) && (rd_p1 == in_rs1);
    assign fwd_b = e_move && (rd_p1 != '0) && !in_use_imm && (rd_p1 == in_rs2);

    always_comb begin
        opa = (in_rs1 == '0) ? '0 : rf[in_rs1];
        opb = (in_rs2 == '0) ? '0 : rf[in_rs2];
        if (fwd_a)
            opa = alu_result;
        if (in_use_imm)
            opb = in_imm;
        else if (fwd_b)
            opb = alu_result;
    end

    // A clear coinciding with a new event keeps only the new event.
    always_comb begin
        sticky_ev  = e_move ? {alu_overflow, alu_carry} : 2'b00;
        sticky_nxt = sticky_clr ? sticky_ev : (sticky_q | sticky_ev);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            op_p1    <= '0;
            rd_p1    <= '0;
            a_p1     <= '0;
            b_p1     <= '0;
            vld_p2   <= 1'b0;
            res_p2   <= '0;
            rd_p2    <= '0;
            flags_p2 <= '0;
            sticky_q <= '0;
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
        end else begin
            // E stage: operands and opcode presented to the alu
            if (accept) begin
                vld_p1 <= 1'b1;
                op_p1  <= in_opcode;
                rd_p1  <= in_rd;
                a_p1   <= opa;
                b_p1   <= opb;
            end else if (e_move) begin
                vld_p1 <= 1'b0;
            end

            // W stage: registered result, flags and register writeback
            if (e_move) begin
                vld_p2   <= 1'b1;
                res_p2   <= alu_result;
                rd_p2    <= rd_p1;
                flags_p2 <= {alu_overflow, alu_carry, alu_zero};
                if (rd_p1 != '0)
                    rf[rd_p1] <= alu_result;
            end else if (out_ready) begin
                vld_p2 <= 1'b0;
            end

            sticky_q <= sticky_nxt;
        end
    end

    assign alu_a        = a_p1;
    assign alu_b        = b_p1;
    assign alu_opcode   = op_p1;
    assign out_valid    = vld_p2;
    assign out_result   = res_p2;
    assign out_rd       = rd_p2;
    assign out_flags    = flags_p2;
    assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small ADD/SUB alu model on the alu ports.
module tb_alu_issue_stage;

    localparam int WIDTH = 16;
    localparam int NREG  = 8;
    localparam int RW    = 3;
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_opcode;
    logic [RW-1:0]    in_rd, in_rs1, in_rs2;
    logic             in_use_imm;
    logic [WIDTH-1:0] in_imm;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [4:0]       alu_opcode;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero, alu_carry, alu_overflow;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [RW-1:0]    out_rd;
    logic [2:0]       out_flags;
    logic [1:0]       sticky_flags;
    logic             sticky_clr;

    int nvec = 0;
    int nerr = 0;

    alu_issue_stage #(.WIDTH(WIDTH), .NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_imm(in_use_imm), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_flags(out_flags),
        .sticky_flags(sticky_flags), .sticky_clr(sticky_clr)
    );

    always #5 clk = ~clk;

    // Stand-in alu: opcode 1 subtracts (carry = borrow), anything else adds.
    logic [WIDTH:0] wide;
    always_comb begin
        wide = '0;
        if (alu_opcode == OP_SUB)
            wide = {1'b0, alu_a} - {1'b0, alu_b};
        else
            wide = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = wide[WIDTH-1:0];
        alu_carry  = wide[WIDTH];
        alu_zero   = (wide[WIDTH-1:0] == '0);
        if (alu_opcode == OP_SUB)
            alu_overflow = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (wide[WIDTH-1] != alu_a[WIDTH-1]);
        else
            alu_overflow = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (wide[WIDTH-1] != alu_a[WIDTH-1]);
    end

    typedef struct {
        logic [4:0]       op;
        logic [RW-1:0]    rd, rs1, rs2;
        logic             use_imm;
        logic [WIDTH-1:0] imm;
        logic [WIDTH-1:0] exp_res;
        logic [2:0]       exp_flags;
        logic [1:0]       exp_sticky;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                         input logic [RW-1:0] rs2, input logic use_imm, input logic [WIDTH-1:0] imm);
        in_valid   = 1'b1;
        in_opcode  = op;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_use_imm = use_imm;
        in_imm     = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sticky_clr = 1'b0;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_use_imm = 1'b0; in_imm = '0;

        //          op      rd  rs1 rs2 imm?  imm       result    flags   sticky
        vecs[0] = '{OP_ADD, 1, 0, 0, 1'b1, 16'h0005, 16'h0005, 3'b000, 2'b00};
        vecs[1] = '{OP_ADD, 2, 1, 0, 1'b1, 16'h0007, 16'h000C, 3'b000, 2'b00};
        vecs[2] = '{OP_SUB, 3, 2, 1, 1'b0, 16'h0000, 16'h0007, 3'b000, 2'b00};
        vecs[3] = '{OP_ADD, 1, 0, 0, 1'b1, 16'h7FFF, 16'h7FFF, 3'b000, 2'b00};
        vecs[4] = '{OP_ADD, 2, 1, 0, 1'b1, 16'h0001, 16'h8000, 3'b100, 2'b10};
        vecs[5] = '{OP_ADD, 5, 0, 0, 1'b1, 16'hFFFF, 16'hFFFF, 3'b000, 2'b10};
        vecs[6] = '{OP_ADD, 4, 5, 0, 1'b1, 16'h0001, 16'h0000, 3'b011, 2'b11};
        vecs[7] = '{OP_SUB, 0, 0, 0, 1'b1, 16'h0009, 16'hFFF7, 3'b010, 2'b11};
        vecs[8] = '{OP_ADD, 1, 0, 0, 1'b1, 16'h0000, 16'h0000, 3'b001, 2'b11};
        vecs[9] = '{OP_SUB, 6, 3, 2, 1'b0, 16'h0000, 16'h8007, 3'b110, 2'b11};

        tick(); tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_out_flags", out_flags, 0);
        check("rst_sticky", sticky_flags, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_opcode", alu_opcode, 0);
        rst = 1'b0;
        tick();

        // Streamed vectors with out_ready held high: one result per cycle, no stall.
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                issue(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].use_imm, vecs[i].imm);
                check($sformatf("v%0d_in_ready", i), in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i > 0) begin
                check($sformatf("v%0d_valid", i-1), out_valid, 1);
                check($sformatf("v%0d_result", i-1), out_result, vecs[i-1].exp_res);
                check($sformatf("v%0d_rd", i-1), out_rd, vecs[i-1].rd);
                check($sformatf("v%0d_flags", i-1), out_flags, vecs[i-1].exp_flags);
                check($sformatf("v%0d_sticky", i-1), sticky_flags, vecs[i-1].exp_sticky);
            end
        end
        tick();
        check("drain_valid", out_valid, 0);

        // Plain clear with no event in flight.
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        check("clr_alone", sticky_flags, 2'b00);

        // Overflow, then clear coinciding with a carry event: only the carry survives.
        issue(OP_ADD, 1, 0, 0, 1'b1, 16'h7FFF); tick();
        issue(OP_ADD, 2, 1, 0, 1'b1, 16'h0001); tick();
        issue(OP_ADD, 7, 5, 0, 1'b1, 16'h0001); tick();
        check("pre_clr_sticky", sticky_flags, 2'b10);
        in_valid = 1'b0;
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        check("clr_set_flags", out_flags, 3'b011);
        check("clr_set_sticky", sticky_flags, 2'b01);
        tick();

        // Backpressure: W holds the first, E holds the second, the third waits.
        out_ready = 1'b0;
        issue(OP_ADD, 1, 0, 0, 1'b1, 16'h0001); tick();
        issue(OP_ADD, 2, 0, 0, 1'b1, 16'h0002);
        check("bp_ready_2nd", in_ready, 1);
        tick();
        issue(OP_ADD, 3, 0, 0, 1'b1, 16'h0003);
        for (int k = 0; k < 3; k++) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_hold_result", out_result, 16'h0001);
            check("bp_hold_rd", out_rd, 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_drain1", out_result, 16'h0002);
        check("bp_drain1_valid", out_valid, 1);
        tick();
        check("bp_drain2", out_result, 16'h0003);
        check("bp_drain2_rd", out_rd, 3);
        tick();
        check("bp_drain_empty", out_valid, 0);

        // Reset with E and W both full; afterwards r3 must read back as zero.
        out_ready = 1'b0;
        issue(OP_ADD, 3, 0, 0, 1'b1, 16'h0055); tick();
        issue(OP_ADD, 6, 0, 0, 1'b1, 16'hFFFF); tick();
        in_valid = 1'b0;
        check("pre_rst_in_ready", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_sticky", sticky_flags, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_alu_a", alu_a, 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        issue(OP_ADD, 1, 3, 0, 1'b1, 16'h0000); tick();
        in_valid = 1'b0;
        tick();
        check("post_rst_r3", out_result, 16'h0000);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_flags", out_flags, 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
